// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit add/subtract split into STAGES slices of W = N/STAGES
// bits. Each slice's carry is registered into the next stage, so the
// critical path is one W-bit ripple. Upper operand slices are delayed to
// meet their carry; lower result slices are delayed to meet the top slice.
// A single global enable advances or freezes the whole pipeline.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  input handshake (in_ready = !out_valid | out_ready)
//   in1, in2             operands A, B (N bits)
//   carry_in             carry (add) / borrow (sub) into bit 0
//   sub                  0 = A + B + cin, 1 = A - B - borrow
//   out_valid/out_ready  output handshake
//   sum                  N-bit result
//   carry_out            raw carry out of bit N-1 (sub: 1 = no borrow)
//   overflow             two's-complement signed overflow

// One W-bit ripple slice: {co, s} = a + b + ci.
module pipelined_adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] tot;

  assign tot = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  assign s   = tot[W-1:0];
  assign co  = tot[W];
endmodule

module pipelined_adder #(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         carry_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);
  localparam int W = N / STAGES;

  if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_param_err
    $error("pipelined_adder: STAGES must lie in 1..N and divide N exactly");
  end

  logic         en;
  logic [N-1:0] b_eff;
  logic         c0;

  // Subtract as A + ~B + ~borrow so a single adder serves both modes.
  assign b_eff    = sub ? ~in2 : in2;
  assign c0       = sub ? ~carry_in : carry_in;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage s adds slice s. Its register holds the finished low result bits
  // [s*W+W-1:0], the carry out of slice s, and (except in the top stage)
  // the operand bits not yet consumed, re-based so the next slice is at bit 0.
  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int LO = s * W;   // first result bit produced here
    localparam int HI = N - LO;  // operand bits still pending at stage input

    logic [HI-1:0]   a_in, b_in;
    logic            c_in, v_in;
    logic [W-1:0]    s_sl;
    logic            c_sl;
    logic [LO+W-1:0] sum_d, sum_q;
    logic            c_d, c_q;
    logic            vld_q;

    if (s == 0) begin : g_src
      assign a_in = in1;
      assign b_in = b_eff;
      assign c_in = c0;
      assign v_in = in_valid;
      always_comb sum_d = s_sl;
    end else begin : g_src
      assign a_in = g_stg[s-1].g_skew.a_q;
      assign b_in = g_stg[s-1].g_skew.b_q;
      assign c_in = g_stg[s-1].c_q;
      assign v_in = g_stg[s-1].vld_q;
      always_comb sum_d = {s_sl, g_stg[s-1].sum_q};
    end

    pipelined_adder_slice #(.W(W)) u_slice (
      .a  (a_in[W-1:0]),
      .b  (b_in[W-1:0]),
      .ci (c_in),
      .s  (s_sl),
      .co (c_sl)
    );

    always_comb c_d = c_sl;

    // Data registers load only with a valid transaction so a bubble never
    // disturbs the last result; the valid bit itself moves on every advance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (en) begin
        vld_q <= v_in;
        if (v_in) begin
          sum_q <= sum_d;
          c_q   <= c_d;
        end
      end
    end

    if (s < STAGES - 1) begin : g_skew
      logic [HI-W-1:0] a_d, a_q, b_d, b_q;

      always_comb begin
        a_d = a_in[HI-1:W];
        b_d = b_in[HI-1:W];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en && v_in) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_top
      logic ovf_d, ovf_q;

      // Carry into the MSB is recovered as a^b^s at the MSB; for W=1 that
      // reduces to the registered carry entering this stage.
      always_comb ovf_d = c_sl ^ (a_in[W-1] ^ b_in[W-1] ^ s_sl[W-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          ovf_q <= 1'b0;
        else if (en && v_in) ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].vld_q;
  assign sum       = g_stg[STAGES-1].sum_q;
  assign carry_out = g_stg[STAGES-1].c_q;
  assign overflow  = g_stg[STAGES-1].g_top.ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: five configurations run side by side, each with
// a queue-based reference (results from plain integer arithmetic, each entry
// aging one step per advancing cycle), directed literal vectors, and a random
// add/sub stream with random backpressure.
module tb_pipelined_adder;
  localparam int NCFG = 5;

  function automatic int cfg_n(input int c);
    case (c)
      2:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_s(input int c);
    case (c)
      0:       return 2;
      3:       return 1;
      4:       return 8;
      default: return 4;
    endcase
  endfunction

  // Packed reference result: bit 17 overflow, bit 16 carry out, low bits sum.
  function automatic longint ref_res(input int n, input longint a, input longint b,
                                     input bit cin, input bit sb);
    longint m, sa, sbv, r, sr;
    bit     c, o;
    m   = longint'(1) << n;
    sa  = (a >= m / 2) ? a - m : a;
    sbv = (b >= m / 2) ? b - m : b;
    if (sb) begin
      r  = a - b - longint'(cin);
      sr = sa - sbv - longint'(cin);
      c  = (r >= 0);
    end else begin
      r  = a + b + longint'(cin);
      sr = sa + sbv + longint'(cin);
      c  = (r >= m);
    end
    o = (sr >= m / 2) || (sr < -(m / 2));
    return (longint'(o) << 17) | (longint'(c) << 16) | (r & (m - 1));
  endfunction

  typedef struct {
    longint r;
    int     age;
  } ent_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    localparam int N = cfg_n(c);
    localparam int S = cfg_s(c);

    logic         rst_n, in_valid, in_ready, carry_in, sub;
    logic         out_valid, out_ready, carry_out, overflow;
    logic [N-1:0] in1, in2, sum;
    ent_t         q[$];

    pipelined_adder #(.N(N), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .carry_in  (carry_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
    );

    function automatic string nm(input string s);
      return $sformatf("cfg%0d(N=%0d,S=%0d) %s", c, N, S, s);
    endfunction

    // Reference: an item becomes visible after S advancing cycles; every
    // item ages together on an advance and nothing moves on a stall.
    always @(negedge clk) begin
      bit   mv, en;
      ent_t e;
      if (!rst_n) begin
        q.delete();
        check(nm("rst out_valid"), longint'(out_valid), 0);
        check(nm("rst in_ready"), longint'(in_ready), 1);
        check(nm("rst sum"), longint'(sum), 0);
        check(nm("rst carry_out"), longint'(carry_out), 0);
        check(nm("rst overflow"), longint'(overflow), 0);
      end else begin
        mv = (q.size() > 0) && (q[0].age == S);
        en = !mv || out_ready;
        check(nm("out_valid"), longint'(out_valid), longint'(mv));
        check(nm("in_ready"), longint'(in_ready), longint'(en));
        if (mv) begin
          check(nm("sum"), longint'(sum), q[0].r & ((longint'(1) << N) - 1));
          check(nm("carry_out"), longint'(carry_out), (q[0].r >> 16) & 1);
          check(nm("overflow"), longint'(overflow), (q[0].r >> 17) & 1);
        end
        if (en) begin
          if (mv) void'(q.pop_front());
          for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
          if (in_valid) begin
            e.r   = ref_res(N, longint'(in1), longint'(in2), carry_in, sub);
            e.age = 1;
            q.push_back(e);
          end
        end
      end
    end

    // Single transaction into an empty pipe with out_ready=1: checks exact
    // latency, a one-cycle out_valid pulse, and literal result values.
    task automatic one_shot(input longint a, input longint b, input bit ci, input bit sb,
                            input longint es, input bit ec, input bit eo);
      out_ready = 1'b1;
      in1 = N'(a); in2 = N'(b); carry_in = ci; sub = sb; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int i = 1; i < S; i++) begin
        @(negedge clk);
        check(nm("os early valid"), longint'(out_valid), 0);
        @(posedge clk);
      end
      @(negedge clk);
      check(nm("os valid"), longint'(out_valid), 1);
      check(nm("os sum"), longint'(sum), es);
      check(nm("os carry_out"), longint'(carry_out), longint'(ec));
      check(nm("os overflow"), longint'(overflow), longint'(eo));
      @(negedge clk);
      check(nm("os valid pulse"), longint'(out_valid), 0);
      @(posedge clk); #1;
    endtask

    initial begin
      int     n, cyc, idx, t;
      bit     acc;
      longint got[$];

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in1 = '0; in2 = '0; carry_in = 1'b0; sub = 1'b0;
      @(negedge clk);
      check(nm("reset in_ready"), longint'(in_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      if (c == 0) begin
        one_shot('hFF, 'h01, 1'b0, 1'b0, 'h00, 1'b1, 1'b0);
        one_shot('h7F, 'h01, 1'b0, 1'b0, 'h80, 1'b0, 1'b1);
        one_shot('h05, 'h07, 1'b0, 1'b1, 'hFE, 1'b0, 1'b0);
        one_shot('h80, 'h01, 1'b0, 1'b1, 'h7F, 1'b1, 1'b1);
      end

      if (c == 1) begin
        // Back-to-back stream (i, 2i) with the output stalled for 3 cycles.
        idx = 0; t = 0;
        while (got.size() < 6 && t < 40) begin
          out_ready = !(t >= 4 && t <= 6);
          in_valid  = (idx < 6);
          in1 = N'(idx + 1); in2 = N'(2 * (idx + 1)); carry_in = 1'b0; sub = 1'b0;
          @(negedge clk);
          if (t >= 4 && t <= 6) begin
            check(nm("stall in_ready"), longint'(in_ready), 0);
            check(nm("stall out_valid"), longint'(out_valid), 1);
            check(nm("stall sum held"), longint'(sum), 3);
          end
          if (out_valid && out_ready) got.push_back(longint'(sum));
          acc = in_valid && in_ready;
          @(posedge clk); #1;
          if (acc) idx++;
          t++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check(nm("stall count"), longint'(got.size()), 6);
        for (int i = 0; i < got.size() && i < 6; i++)
          check(nm("stall order"), got[i], longint'(3 * (i + 1)));

        // Four pushes: one result at the output, three still in flight.
        for (int i = 0; i < 4; i++) begin
          in_valid = 1'b1; in1 = N'(10 + i); in2 = N'(1);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check(nm("pre-reset valid"), longint'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check(nm("async rst out_valid"), longint'(out_valid), 0);
        check(nm("async rst sum"), longint'(sum), 0);
        check(nm("async rst carry_out"), longint'(carry_out), 0);
        check(nm("async rst in_ready"), longint'(in_ready), 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          check(nm("no stale output"), longint'(out_valid), 0);
          @(posedge clk); #1;
        end
        one_shot('h12, 'h34, 1'b1, 1'b0, 'h47, 1'b0, 1'b0);
      end

      if (c == 2) begin
        one_shot('h0FFF, 'h0001, 1'b0, 1'b0, 'h1000, 1'b0, 1'b0);
        one_shot('hFFFF, 'h0000, 1'b1, 1'b0, 'h0000, 1'b1, 1'b0);
        one_shot('h8000, 'h8000, 1'b0, 1'b0, 'h0000, 1'b1, 1'b1);
      end

      // Random add/sub stream with random backpressure.
      n = 0; cyc = 0;
      while (n < 1000 && cyc < 6000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        in1 = N'($urandom); in2 = N'($urandom);
        if ($urandom_range(0, 7) == 0) in1 = '1;
        carry_in = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (in_valid && in_ready) n++;
        @(posedge clk); #1;
        cyc++;
      end
      check(nm("random accepts"), longint'(n), 1000);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (S + 2) @(posedge clk);
      done_cnt++;
    end
  end

  initial begin
    // Pin the reference model to hand-computed values.
    check("model 8b FF+01", ref_res(8, 'hFF, 'h01, 1'b0, 1'b0), 'h10000);
    check("model 8b 7F+01", ref_res(8, 'h7F, 'h01, 1'b0, 1'b0), 'h20080);
    check("model 8b 05-07", ref_res(8, 'h05, 'h07, 1'b0, 1'b1), 'h000FE);
    check("model 8b 80-01", ref_res(8, 'h80, 'h01, 1'b0, 1'b1), 'h3007F);
    check("model 16b FFFF+0+1", ref_res(16, 'hFFFF, 'h0, 1'b1, 1'b0), 'h10000);
    for (int t = 0; t < 30000 && done_cnt < NCFG; t++) @(posedge clk);
    check("all configs finished", longint'(done_cnt), NCFG);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
